// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader driving the CPU program-memory write port
//
// Purpose:
//   Parses SYNC, base[31:0] (LE), len[15:0] (LE), len payload bytes and an
//   XOR checksum from a valid/ready byte stream. Each payload byte is written
//   to program memory one cycle after acceptance. The CPU is held in reset
//   until a frame loads with a matching checksum.
//
// Ports:
//   clk           in   1   clock
//   reset         in   1   synchronous, active-high reset
//   in_valid      in   1   in_data holds a byte
//   in_data       in   8   stream byte
//   in_ready      out  1   always 1; loader takes one byte per cycle
//   write_address out  32  program-memory byte address
//   write_data    out  8   program-memory byte
//   write_enable  out  1   one-cycle write strobe
//   cpu_reset_n   out  1   active-low CPU reset, high only in RUN
//   load_done     out  1   high in RUN
//   load_error    out  1   high in ERROR
//   byte_count    out  16  payload bytes written in the current or last frame

module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] MAX_LEN   = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] write_address,
  output logic [7:0]  write_data,
  output logic        write_enable,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] byte_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;      // byte index within the address/length fields
  logic [31:0] r_base;
  logic [15:0] r_len;
  logic [7:0]  r_csum;

  state_t      w_next;
  logic        w_acc;
  logic        w_sync;
  logic [15:0] w_len_full;
  logic [15:0] w_cnt_inc;

  // No backpressure: every offered byte is taken.
  assign in_ready   = 1'b1;
  assign w_acc      = in_valid;
  assign w_sync     = (in_data == SYNC_BYTE);
  // Length as it will be once the high byte currently on in_data is stored.
  assign w_len_full = {in_data, r_len[7:0]};
  assign w_cnt_inc  = byte_count + 16'd1;

  always_comb begin
    w_next = r_state;
    if (w_acc) begin
      case (r_state)
        S_IDLE:  if (w_sync) w_next = S_ADDR;
        S_ADDR:  if (r_idx == 2'd3) w_next = S_LEN;
        S_LEN: begin
          if (r_idx[0]) begin
            if (w_len_full > MAX_LEN)       w_next = S_ERROR;
            else if (w_len_full == 16'd0)   w_next = S_CSUM;
            else                            w_next = S_DATA;
          end
        end
        // byte_count still holds the count before this byte is written.
        S_DATA:  if (w_cnt_inc == r_len) w_next = S_CSUM;
        S_CSUM:  w_next = (in_data == r_csum) ? S_RUN : S_ERROR;
        S_RUN:   if (w_sync) w_next = S_ADDR;
        S_ERROR: if (w_sync) w_next = S_ADDR;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_base        <= 32'd0;
      r_len         <= 16'd0;
      r_csum        <= 8'd0;
      write_address <= 32'd0;
      write_data    <= 8'd0;
      write_enable  <= 1'b0;
      cpu_reset_n   <= 1'b0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      byte_count    <= 16'd0;
    end else begin
      r_state      <= w_next;
      // Status flags follow the state being entered, so they move on the
      // same edge as the transition into or out of RUN/ERROR.
      cpu_reset_n  <= (w_next == S_RUN);
      load_done    <= (w_next == S_RUN);
      load_error   <= (w_next == S_ERROR);
      write_enable <= 1'b0;

      if (w_acc) begin
        case (r_state)
          S_IDLE, S_RUN, S_ERROR: begin
            if (w_sync) r_idx <= 2'd0;
          end
          S_ADDR: begin
            r_base[{r_idx, 3'b000} +: 8] <= in_data;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              // Entering LEN: start a fresh checksum and write count.
              r_csum     <= 8'd0;
              byte_count <= 16'd0;
            end
          end
          S_LEN: begin
            if (!r_idx[0]) begin
              r_len[7:0] <= in_data;
              r_idx      <= 2'd1;
            end else begin
              r_len[15:8] <= in_data;
              r_idx       <= 2'd0;
            end
          end
          S_DATA: begin
            write_enable  <= 1'b1;
            write_data    <= in_data;
            write_address <= r_base + {16'd0, byte_count};
            r_csum        <= r_csum ^ in_data;
            byte_count    <= w_cnt_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader

module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] write_address;
  logic [7:0]  write_data;
  logic        write_enable;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;
  logic [15:0] byte_count;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  prog_loader dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .write_address (write_address),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .cpu_reset_n   (cpu_reset_n),
    .load_done     (load_done),
    .load_error    (load_error),
    .byte_count    (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write strobes away from the active edge.
  always @(negedge clk) begin
    if (write_enable === 1'b1) wr_cnt = wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, pass the edge, land 1ns after it.
  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"},    {31'd0, in_ready},     32'd1);
    chk({tag, ".we"},          {31'd0, write_enable}, 32'd0);
    chk({tag, ".addr"},        write_address,         32'd0);
    chk({tag, ".data"},        {24'd0, write_data},   32'd0);
    chk({tag, ".cpu_rst_n"},   {31'd0, cpu_reset_n},  32'd0);
    chk({tag, ".done"},        {31'd0, load_done},    32'd0);
    chk({tag, ".err"},         {31'd0, load_error},   32'd0);
    chk({tag, ".byte_count"},  {16'd0, byte_count},   32'd0);
  endtask

  // Everything after the sync byte. Each payload byte is checked on the
  // strobe cycle that follows it; gap cycles must show no strobe.
  task automatic send_body(input string tag, input logic [31:0] base,
                           input logic [7:0] payload[$], input logic [7:0] csum,
                           input int gap);
    logic [15:0] len;
    len = 16'(payload.size());
    for (int i = 0; i < 4; i++) begin
      step(1'b1, base[8*i +: 8]);
      for (int g = 0; g < gap; g++) step(1'b0, 8'h00);
    end
    step(1'b1, len[7:0]);
    for (int g = 0; g < gap; g++) step(1'b0, 8'h00);
    step(1'b1, len[15:8]);
    for (int g = 0; g < gap; g++) step(1'b0, 8'h00);
    for (int i = 0; i < payload.size(); i++) begin
      step(1'b1, payload[i]);
      chk({tag, ".we"},   {31'd0, write_enable}, 32'd1);
      chk({tag, ".addr"}, write_address,         base + 32'(i));
      chk({tag, ".data"}, {24'd0, write_data},   {24'd0, payload[i]});
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 8'h00);
        if (g == 0) begin
          chk({tag, ".gap_we"},   {31'd0, write_enable}, 32'd0);
          chk({tag, ".gap_addr"}, write_address,         base + 32'(i));
        end
      end
    end
    chk({tag, ".pre_csum_rst"}, {31'd0, cpu_reset_n}, 32'd0);
    step(1'b1, csum);
  endtask

  task automatic chk_run(input string tag, input int nbytes);
    chk({tag, ".cpu_rst_n"}, {31'd0, cpu_reset_n}, 32'd1);
    chk({tag, ".done"},      {31'd0, load_done},   32'd1);
    chk({tag, ".err"},       {31'd0, load_error},  32'd0);
    chk({tag, ".count"},     {16'd0, byte_count},  32'(nbytes));
    chk({tag, ".writes"},    32'(wr_cnt),          32'(nbytes));
  endtask

  initial begin
    logic [7:0] pl[$];
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // 1: reset values, then a clean 4-byte frame at address 0
    do_reset();
    chk_reset_vals("t1.reset");
    wr_cnt = 0;
    pl = '{8'h13, 8'h00, 8'h00, 8'h00};
    step(1'b1, 8'hA5);
    send_body("t1", 32'h0, pl, 8'h13, 0);
    chk_run("t1.run", 4);

    // 2: bad checksum, then recovery with a good frame
    do_reset();
    wr_cnt = 0;
    step(1'b1, 8'hA5);
    send_body("t2", 32'h0, pl, 8'h12, 0);
    chk("t2.err",       {31'd0, load_error},  32'd1);
    chk("t2.cpu_rst_n", {31'd0, cpu_reset_n}, 32'd0);
    chk("t2.done",      {31'd0, load_done},   32'd0);
    chk("t2.writes",    32'(wr_cnt),          32'd4);
    step(1'b1, 8'h77);
    chk("t2.ignore_err", {31'd0, load_error}, 32'd1);
    step(1'b1, 8'hA5);
    chk("t2.err_clr",   {31'd0, load_error},  32'd0);
    wr_cnt = 0;
    send_body("t2b", 32'h0, pl, 8'h13, 0);
    chk_run("t2b.run", 4);

    // 3: gapped frame at 0x100
    do_reset();
    wr_cnt = 0;
    pl = '{8'hAB, 8'hCD};
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    send_body("t3", 32'h0000_0100, pl, 8'h66, 3);
    chk_run("t3.run", 2);

    // 4a: len = MAX_LEN+1 errors on the 2nd length byte
    do_reset();
    wr_cnt = 0;
    step(1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    chk("t4a.not_yet_err", {31'd0, load_error}, 32'd0);
    step(1'b1, 8'h04);
    chk("t4a.err",       {31'd0, load_error},  32'd1);
    chk("t4a.cpu_rst_n", {31'd0, cpu_reset_n}, 32'd0);
    step(1'b1, 8'h55);
    chk("t4a.writes",    32'(wr_cnt),          32'd0);
    // 4b: len = 0 with csum 00 from ERROR
    pl = {};
    step(1'b1, 8'hA5);
    send_body("t4b", 32'h0000_2000, pl, 8'h00, 0);
    chk_run("t4b.run", 0);
    // 4c: len = MAX_LEN is legal
    do_reset();
    wr_cnt = 0;
    pl = {};
    for (int i = 0; i < 1024; i++) pl.push_back(8'(i));
    step(1'b1, 8'hA5);
    send_body("t4c", 32'hFFFF_FF00, pl, 8'h00, 0);
    chk_run("t4c.run", 1024);

    // 5: leading garbage, A5 as payload, re-sync from RUN
    do_reset();
    wr_cnt = 0;
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    chk("t5.garbage_we", {31'd0, write_enable}, 32'd0);
    pl = '{8'h5A, 8'hA5};
    step(1'b1, 8'hA5);
    send_body("t5", 32'h0000_0200, pl, 8'hFF, 0);
    chk_run("t5.run", 2);
    step(1'b1, 8'h11);
    chk("t5.run_ignore", {31'd0, cpu_reset_n}, 32'd1);
    step(1'b1, 8'hA5);
    chk("t5.reload_rst_n", {31'd0, cpu_reset_n}, 32'd0);
    chk("t5.reload_done",  {31'd0, load_done},   32'd0);

    // 6: reset after the 2nd payload byte, then a fresh load
    do_reset();
    wr_cnt = 0;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h40);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h04);
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    chk("t6.addr_2nd", write_address, 32'h0000_0041);
    reset = 1'b1;
    step(1'b1, 8'h03);
    chk_reset_vals("t6.mid_reset");
    step(1'b1, 8'h04);
    reset = 1'b0;
    step(1'b1, 8'h00);
    chk("t6.writes_aborted", 32'(wr_cnt), 32'd2);
    wr_cnt = 0;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    step(1'b1, 8'hA5);
    send_body("t6", 32'h0000_0040, pl, 8'h04, 0);
    chk_run("t6.run", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
